vec_xfer_seq: RTL and testbench

VEC_XFER_SEQ -- requirements
Module: vec_xfer_seq

---
 rtl/vec_xfer_seq.sv | 112 +++++++++++
 tb/tb_vec_xfer_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/vec_xfer_seq.sv
// Vector load/store sequencer: moves up to NUM_ELEM words between a flat vector
// register and a word-addressed memory with one-cycle read latency.
module vec_xfer_seq #(
  parameter int ELEM_W   = 16,
  parameter int NUM_ELEM = 16,
  parameter int ADDR_W   = 16,
  localparam int CNT_W   = $clog2(NUM_ELEM),
  localparam int VEC_W   = ELEM_W*NUM_ELEM
) (
  input  logic              Clk1,
  input  logic              Reset,
  input  logic              start,
  input  logic              is_store,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic [VEC_W-1:0]  wdata_vec,
  input  logic [ELEM_W-1:0] DataIn,
  output logic              busy,
  output logic              done,
  output logic [VEC_W-1:0]  rdata_vec,
  output logic [ADDR_W-1:0] Addr,
  output logic              RD,
  output logic              WR,
  output logic [ELEM_W-1:0] dataOut
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_STORE, S_DONE} state_t;

  typedef struct packed {
    logic [CNT_W-1:0]                   last;
    logic [NUM_ELEM-1:0][ELEM_W-1:0]    wdata;
  } req_t;

  state_t                          state;
  req_t                            req;
  logic [CNT_W-1:0]                idx;
  logic [NUM_ELEM-1:0][ELEM_W-1:0] rdata_q;

  assign rdata_vec = rdata_q;

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      state   <= S_IDLE;
      req     <= '0;
      idx     <= '0;
      rdata_q <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      RD      <= 1'b0;
      WR      <= 1'b0;
      Addr    <= '0;
      dataOut <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          req.last  <= count;
          req.wdata <= wdata_vec;
          idx       <= '0;
          busy      <= 1'b1;
          Addr      <= base_addr;
          if (is_store) begin
            state   <= S_STORE;
            WR      <= 1'b1;
            dataOut <= wdata_vec[ELEM_W-1:0];
          end else begin
            // unused tail elements must read back as zero once the load ends
            state   <= S_LOAD;
            RD      <= 1'b1;
            rdata_q <= '0;
          end
        end
        S_LOAD: begin
          // DataIn this cycle answers the read issued one cycle earlier
          if (idx != '0) rdata_q[idx - 1'b1] <= DataIn;
          if (idx == req.last) begin
            state <= S_DRAIN;
            RD    <= 1'b0;
            Addr  <= '0;
          end else begin
            idx  <= idx + 1'b1;
            Addr <= Addr + 1'b1;
          end
        end
        S_DRAIN: begin
          rdata_q[req.last] <= DataIn;
          state             <= S_DONE;
          done              <= 1'b1;
        end
        S_STORE: begin
          if (idx == req.last) begin
            state   <= S_DONE;
            WR      <= 1'b0;
            Addr    <= '0;
            dataOut <= '0;
            done    <= 1'b1;
          end else begin
            idx     <= idx + 1'b1;
            Addr    <= Addr + 1'b1;
            dataOut <= req.wdata[idx + 1'b1];
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_xfer_seq.sv
// Bench for vec_xfer_seq: per-cycle comparison against a transfer-schedule model
// plus directed scenarios with literal expectations.
module tb_vec_xfer_seq;
  localparam int VW = 256;

  logic          Clk1 = 1'b0, Reset = 1'b1, start = 1'b0, is_store = 1'b0;
  logic [15:0]   base_addr = '0;
  logic [3:0]    count = '0;
  logic [VW-1:0] wdata_vec = '0;
  logic [15:0]   DataIn = 16'hDEAD;
  logic          busy, done, RD, WR;
  logic [VW-1:0] rdata_vec;
  logic [15:0]   Addr, dataOut;

  always #5 Clk1 = ~Clk1;

  vec_xfer_seq dut (
    .Clk1(Clk1), .Reset(Reset), .start(start), .is_store(is_store),
    .base_addr(base_addr), .count(count), .wdata_vec(wdata_vec), .DataIn(DataIn),
    .busy(busy), .done(done), .rdata_vec(rdata_vec), .Addr(Addr),
    .RD(RD), .WR(WR), .dataOut(dataOut)
  );

  logic [15:0]   mem [0:65535];
  int            checks = 0, failures = 0, cyc = 0, done_cnt = 0;
  int            done_q[$];
  logic [15:0]   rd_log[$];

  // model of the transfer in flight: start cycle, kind, base, length, data
  bit            active = 0, armed = 0, m_store = 0, rdata_valid = 1, pend = 0;
  int            t0 = 0, m_n = 1;
  logic [15:0]   m_base = '0, paddr = '0;
  logic [VW-1:0] m_wd = '0, rdata_exp = '0;

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge Clk1) begin : mdl
    int k, last;
    logic e_busy, e_done, e_rd, e_wr;
    logic [15:0] e_addr, e_dout;
    // memory: one-cycle read latency, writes land immediately
    DataIn = pend ? mem[paddr] : 16'hDEAD;
    pend = RD; paddr = Addr;
    if (WR) mem[Addr] = dataOut;
    if (RD) rd_log.push_back(Addr);
    if (done) begin done_cnt++; done_q.push_back(cyc); end

    k = cyc - t0;
    last = m_store ? m_n + 1 : m_n + 2;
    if (active && k > last) active = 0;
    e_busy = 0; e_done = 0; e_rd = 0; e_wr = 0; e_addr = '0; e_dout = '0;
    if (active) begin
      e_busy = 1;
      e_done = (k == last);
      if (m_store) begin
        e_wr = (k <= m_n);
        if (e_wr) begin
          e_addr = m_base + 16'(k - 1);
          e_dout = m_wd[(k-1)*16 +: 16];
        end
      end else begin
        e_rd = (k <= m_n);
        if (e_rd) e_addr = m_base + 16'(k - 1);
        if (k < last) rdata_valid = 0;
        else begin
          for (int j = 0; j < 16; j++)
            rdata_exp[j*16 +: 16] = (j < m_n) ? mem[m_base + 16'(j)] : 16'h0000;
          rdata_valid = 1;
        end
      end
    end
    if (armed) begin
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("RD", RD, e_rd);
      chk("WR", WR, e_wr);
      chk("Addr", Addr, e_addr);
      chk("dataOut", dataOut, e_dout);
      chk("rd_wr_excl", RD & WR, 1'b0);
      if (rdata_valid) chk("rdata_vec", rdata_vec, rdata_exp);
    end

    if (Reset) begin
      active = 0; rdata_exp = '0; rdata_valid = 1; armed = 1;
    end else if (!active && start) begin
      active = 1; t0 = cyc; m_store = is_store; m_base = base_addr;
      m_n = int'(count) + 1; m_wd = wdata_vec;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge Clk1); #2;
  endtask

  task automatic go(input bit st, input logic [15:0] b, input logic [3:0] c,
                    input logic [VW-1:0] wd, output int s);
    is_store = st; base_addr = b; count = c; wdata_vec = wd; start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 100) begin tick(); n++; end
    chk(nm, busy, 1'b0);
  endtask

  initial begin
    int s, d0;
    logic [VW-1:0] wd;
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'h5A5A;

    repeat (3) tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_rdata", rdata_vec, '0);
    chk("rst_addr", Addr, 16'h0000);
    Reset = 1'b0;
    tick();

    // full 16-element load
    for (int j = 0; j < 16; j++) mem[16'h0100 + j] = 16'hA000 + 16'(j);
    go(1'b0, 16'h0100, 4'd15, '0, s);
    wait_idle("full_idle");
    chk("full_done_cyc", done_q.size() > 0 ? done_q[$] - s : -1, 18);
    chk("full_e0", rdata_vec[15:0], 16'hA000);
    chk("full_e15", rdata_vec[255:240], 16'hA00F);

    // 3-element load wrapping past 0xFFFF
    mem[16'hFFFE] = 16'h1234; mem[16'hFFFF] = 16'h5678; mem[16'h0000] = 16'h9ABC;
    rd_log.delete();
    go(1'b0, 16'hFFFE, 4'd2, '0, s);
    wait_idle("wrap_idle");
    chk("wrap_done_cyc", done_q[$] - s, 5);
    chk("wrap_nrd", rd_log.size(), 3);
    chk("wrap_a0", rd_log[0], 16'hFFFE);
    chk("wrap_a1", rd_log[1], 16'hFFFF);
    chk("wrap_a2", rd_log[2], 16'h0000);
    chk("wrap_e0", rdata_vec[15:0], 16'h1234);
    chk("wrap_e2", rdata_vec[47:32], 16'h9ABC);
    chk("wrap_tail0", rdata_vec[255:48], '0);

    // 4-element store; inputs scrambled after accept, start pulsed while busy
    for (int j = 0; j < 16; j++) wd[j*16 +: 16] = 16'(16'h1111 * (j + 1));
    d0 = done_cnt;
    go(1'b1, 16'h0040, 4'd3, wd, s);
    wdata_vec = ~wd; base_addr = 16'h7777; count = 4'd15; is_store = 1'b0;
    tick(); tick();
    start = 1'b1; tick();
    start = 1'b0; tick();
    start = 1'b1; tick();
    start = 1'b0;
    tick();
    wait_idle("st_idle");
    chk("st_done_count", done_cnt - d0, 1);
    chk("st_done_cyc", done_q[$] - s, 5);
    chk("st_m40", mem[16'h0040], 16'h1111);
    chk("st_m41", mem[16'h0041], 16'h2222);
    chk("st_m42", mem[16'h0042], 16'h3333);
    chk("st_m43", mem[16'h0043], 16'h4444);
    chk("st_m44", mem[16'h0044], 16'h0044 ^ 16'h5A5A);
    chk("st_rdata_kept", rdata_vec[47:32], 16'h9ABC);

    // reset in cycle 6 of a full load
    d0 = done_cnt;
    go(1'b0, 16'h0200, 4'd15, '0, s);
    repeat (5) tick();
    Reset = 1'b1;
    tick();
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_rd", RD, 1'b0);
    chk("mid_rst_addr", Addr, 16'h0000);
    chk("mid_rst_rdata", rdata_vec, '0);
    Reset = 1'b0;
    repeat (20) tick();
    chk("mid_rst_nodone", done_cnt - d0, 0);

    // start held across two back-to-back 2-element loads
    d0 = done_cnt;
    is_store = 1'b0; base_addr = 16'h0100; count = 4'd1; wdata_vec = '0;
    start = 1'b1; s = cyc;
    repeat (6) tick();
    start = 1'b0;
    wait_idle("b2b_idle");
    chk("b2b_done_count", done_cnt - d0, 2);
    chk("b2b_first_done", done_q[$-1] - s, 4);
    chk("b2b_gap", done_q[$] - done_q[$-1], 5);
    chk("b2b_e1", rdata_vec[31:16], 16'hA001);
    chk("b2b_tail0", rdata_vec[255:32], '0);

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
